// File: rtl/conv_window_5x5.sv
// conv_window_5x5: 5x5 signed-kernel filter over the bram_delay row taps.
// One pixel in, one filtered pixel out per clock; status delayed to match.
module conv_window_5x5 #(
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned COEF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       pa,
    input  logic [23:0]       pb,
    input  logic [23:0]       pc,
    input  logic [23:0]       pd,
    input  logic [23:0]       pe,
    input  logic [2:0]        stat_in,
    input  logic              coef_we,
    input  logic [4:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [23:0]       dout,
    output logic [2:0]        stat_o
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned NCH    = 3;
    localparam int unsigned NROW   = 5;
    localparam int unsigned NTAP   = NROW * NROW;
    localparam int unsigned TAP_W  = NCH * PIX_W;
    localparam int unsigned COL_W  = NROW * TAP_W;
    localparam int unsigned LAT    = 6;
    localparam int unsigned CENTRE = 12;
    localparam int unsigned PROD_W = PIX_W + 1 + COEF_W;
    localparam int unsigned PSUM_W = PROD_W + 3;
    localparam int unsigned SUM_W  = PROD_W + 5;

    logic        [COL_W-1:0]  col_q   [NROW];
    logic        [COL_W-1:0]  col_d   [NROW];
    logic signed [COEF_W-1:0] coef_q  [NTAP];
    logic signed [COEF_W-1:0] coef_d  [NTAP];
    logic signed [PROD_W-1:0] prod_q  [NCH][NTAP];
    logic signed [PROD_W-1:0] prod_d  [NCH][NTAP];
    logic signed [PSUM_W-1:0] psum_q  [NCH][NROW];
    logic signed [PSUM_W-1:0] psum_d  [NCH][NROW];
    logic signed [SUM_W-1:0]  sum_q   [NCH];
    logic signed [SUM_W-1:0]  sum_d   [NCH];
    logic        [2:0]        stat_q  [LAT];
    logic        [2:0]        stat_d  [LAT];
    logic        [23:0]       dout_q, dout_d;
    logic        [2:0]        stat_o_q, stat_o_d;
    logic        [PIX_W-1:0]  pix;
    logic signed [SUM_W-1:0]  shifted;

    // Column shift register; blanking columns enter as zero
    always_comb begin
        col_d[0] = stat_in[0] ? {pa, pb, pc, pd, pe} : '0;
        for (int i = 1; i < NROW; i++) col_d[i] = col_q[i-1];
    end

    // Kernel write port; out-of-range addresses match no entry
    always_comb begin
        for (int unsigned i = 0; i < NTAP; i++) begin
            coef_d[i] = coef_q[i];
            if (coef_we && (coef_addr == 5'(i))) coef_d[i] = coef_data;
        end
    end

    // Products: kernel column 0 pairs with the oldest column register (c4)
    always_comb begin
        pix = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < NROW; r++) begin
                for (int j = 0; j < NROW; j++) begin
                    pix = col_q[NROW-1-j][(NROW-1-r)*TAP_W + ch*PIX_W +: PIX_W];
                    prod_d[ch][r*NROW+j] = PROD_W'($signed({1'b0, pix})) * PROD_W'(coef_q[r*NROW+j]);
                end
            end
        end
    end

    // Per-row partial sums
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < NROW; r++) begin
                psum_d[ch][r] = '0;
                for (int j = 0; j < NROW; j++)
                    psum_d[ch][r] = psum_d[ch][r] + PSUM_W'(prod_q[ch][r*NROW+j]);
            end
        end
    end

    // Full per-channel sums
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            sum_d[ch] = '0;
            for (int r = 0; r < NROW; r++)
                sum_d[ch] = sum_d[ch] + SUM_W'(psum_q[ch][r]);
        end
    end

    // Shift, clamp to 0..255, blank when the matching status has DE low
    always_comb begin
        dout_d  = '0;
        shifted = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            shifted = sum_q[ch] >>> SHIFT;
            if (shifted < 0)
                dout_d[ch*PIX_W +: PIX_W] = '0;
            else if (shifted > SUM_W'(255))
                dout_d[ch*PIX_W +: PIX_W] = 8'hFF;
            else
                dout_d[ch*PIX_W +: PIX_W] = shifted[PIX_W-1:0];
        end
        if (!stat_q[LAT-1][0]) dout_d = '0;
    end

    // Status delay line; last stage feeds the output register alongside dout
    always_comb begin
        stat_d[0] = stat_in;
        for (int i = 1; i < LAT; i++) stat_d[i] = stat_q[i-1];
        stat_o_d = stat_q[LAT-1];
    end

    // All state registers; reset restores the identity kernel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NROW; i++) col_q[i] <= '0;
            for (int unsigned i = 0; i < NTAP; i++)
                coef_q[i] <= (i == CENTRE) ? COEF_W'(1 << SHIFT) : '0;
            for (int ch = 0; ch < NCH; ch++) begin
                for (int i = 0; i < NTAP; i++) prod_q[ch][i] <= '0;
                for (int r = 0; r < NROW; r++) psum_q[ch][r] <= '0;
                sum_q[ch] <= '0;
            end
            for (int i = 0; i < LAT; i++) stat_q[i] <= '0;
            dout_q   <= '0;
            stat_o_q <= '0;
        end else begin
            col_q    <= col_d;
            coef_q   <= coef_d;
            prod_q   <= prod_d;
            psum_q   <= psum_d;
            sum_q    <= sum_d;
            stat_q   <= stat_d;
            dout_q   <= dout_d;
            stat_o_q <= stat_o_d;
        end
    end

    assign dout   = dout_q;
    assign stat_o = stat_o_q;

endmodule

// File: tb/tb_conv_window_5x5.sv
// Scoreboard bench for conv_window_5x5: column/status history model feeds an
// expected-output queue that an independent monitor drains every clock.
module tb_conv_window_5x5;

    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pa, pb, pc, pd, pe;
    logic [2:0]  stat_in;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [23:0] dout;
    logic [2:0]  stat_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_1414 = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Reference state: last 5 gated columns, last 3 status words, kernel values
    logic [119:0] hcol[$];
    logic [2:0]   hstat[$];
    int           mcoef[25];
    logic [26:0]  exp_q[$];

    conv_window_5x5 #(.SHIFT(SHIFT), .COEF_W(8)) dut (
        .clk(clk), .rst(rst),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
        .stat_in(stat_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .dout(dout), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state right after reset: empty history, identity kernel, and four
    // outputs still coming from the cleared pipeline
    task automatic model_reset();
        hcol = {};
        hstat = {};
        exp_q = {};
        repeat (5) hcol.push_back('0);
        repeat (3) hstat.push_back('0);
        for (int i = 0; i < 25; i++) mcoef[i] = (i == 12) ? (1 << SHIFT) : 0;
        repeat (4) exp_q.push_back('0);
    endtask

    // Window centred on the column sampled two edges ago, kernel as of this edge;
    // that pixel appears four edges later
    task automatic model_step(input logic [119:0] col, input logic [2:0] st,
                              input logic we, input logic [4:0] addr, input logic [7:0] data);
        logic [23:0]  pix_out;
        logic [119:0] cc;
        logic [7:0]   p;
        logic signed [7:0] sd;
        int acc;
        if (we && addr < 5'd25) begin
            sd = data;
            mcoef[addr] = int'(sd);
        end
        hcol.push_back(st[0] ? col : 120'd0);
        void'(hcol.pop_front());
        hstat.push_back(st);
        void'(hstat.pop_front());
        pix_out = '0;
        for (int ch = 0; ch < 3; ch++) begin
            acc = 0;
            for (int r = 0; r < 5; r++) begin
                for (int j = 0; j < 5; j++) begin
                    cc = hcol[j];
                    p = cc[(4-r)*24 + ch*8 +: 8];
                    acc += int'(p) * mcoef[r*5+j];
                end
            end
            acc = acc >>> SHIFT;
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            pix_out[ch*8 +: 8] = 8'(acc);
        end
        if (!hstat[0][0]) pix_out = '0;
        exp_q.push_back({hstat[0], pix_out});
    endtask

    // One clock of stimulus: called and returns at a falling edge
    task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                         input logic [23:0] d, input logic [23:0] e, input logic [2:0] st,
                         input logic we, input logic [4:0] addr, input logic [7:0] data);
        pa = a; pb = b; pc = c; pd = d; pe = e;
        stat_in = st; coef_we = we; coef_addr = addr; coef_data = data;
        @(posedge clk);
        model_step({a, b, c, d, e}, st, we, addr, data);
        @(negedge clk);
    endtask

    task automatic drive_const(input logic [23:0] k, input logic de, input int n);
        for (int i = 0; i < n; i++) drive(k, k, k, k, k, {2'b00, de}, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic rand_inputs();
        pa = 24'($urandom); pb = 24'($urandom); pc = 24'($urandom);
        pd = 24'($urandom); pe = 24'($urandom);
        stat_in = 3'($urandom); coef_we = 1'($urandom);
        coef_addr = 5'($urandom); coef_data = 8'($urandom);
    endtask

    // Reset with random inputs; outputs must clear immediately and stay clear
    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        rst = 1'b1;
        rand_inputs();
        #1;
        check("async_rst_dout", 32'(dout), 32'h0);
        check("async_rst_stat", 32'(stat_o), 32'h0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rand_inputs();
            check("rst_dout", 32'(dout), 32'h0);
            check("rst_stat", 32'(stat_o), 32'h0);
        end
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: one expected entry per clock while enabled
    initial begin
        logic [26:0] e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("dout@%0d", cyc), 32'(dout), 32'(e[23:0]));
                    check($sformatf("stat_o@%0d", cyc), 32'(stat_o), 32'(e[26:24]));
                    if (dout == 24'h141414) cnt_1414++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pa = '0; pb = '0; pc = '0; pd = '0; pe = '0;
        stat_in = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        @(negedge clk);
        do_reset(4);

        // Identity latency with counter on the centre row, sync pulses on status
        for (int i = 0; i < 40; i++)
            drive(24'h123456, 24'h123456, 24'(i * 7 + 1), 24'h123456, 24'h123456,
                  {(i >= 20 && i <= 21), (i >= 10 && i <= 12), 1'b1}, 1'b0, 5'd0, 8'd0);

        // Box kernel: all ones
        for (int i = 0; i < 25; i++)
            drive(24'h101010, 24'h101010, 24'h101010, 24'h101010, 24'h101010,
                  3'b001, 1'b1, 5'(i), 8'd1);
        drive_const(24'h101010, 1'b1, 12);
        check("box_full", 32'(dout), 32'h191919);

        // Out-of-range write must leave the kernel alone
        drive(24'h101010, 24'h101010, 24'h101010, 24'h101010, 24'h101010,
              3'b001, 1'b1, 5'd31, 8'h55);
        drive_const(24'h101010, 1'b1, 10);
        check("addr31_ignored", 32'(dout), 32'h191919);

        // One blank column mid-line: four neighbours lose one column, centre itself is blanked
        cnt_1414 = 0;
        drive_const(24'h101010, 1'b1, 10);
        drive_const(24'h101010, 1'b0, 1);
        drive_const(24'h101010, 1'b1, 12);
        check("de_gap_count", 32'(cnt_1414), 32'd4);

        // Negative clamp: kernel = -1 at centre only
        for (int i = 0; i < 25; i++)
            drive(24'h00FF80, 24'h00FF80, 24'h00FF80, 24'h00FF80, 24'h00FF80,
                  3'b001, 1'b1, 5'(i), (i == 12) ? 8'hFF : 8'h00);
        drive_const(24'h00FF80, 1'b1, 10);
        check("clamp_neg", 32'(dout), 32'h000000);

        // Overflow clamp: centre = 127; 10*127>>4=79, 255*127>>4 saturates, 2*127>>4=15
        drive(24'h0AFF02, 24'h0AFF02, 24'h0AFF02, 24'h0AFF02, 24'h0AFF02,
              3'b001, 1'b1, 5'd12, 8'd127);
        drive_const(24'h0AFF02, 1'b1, 10);
        check("clamp_pos", 32'(dout), 32'h4FFF0F);

        // Random traffic with occasional kernel writes (including invalid addresses)
        for (int i = 0; i < 300; i++) begin
            logic we;
            logic [7:0] cd;
            we = ($urandom_range(0, 7) == 0);
            cd = 8'($urandom_range(0, 40)) - 8'd12;
            drive(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
                  {2'($urandom), 1'($urandom_range(0, 7) != 0)},
                  we, 5'($urandom_range(0, 31)), cd);
            if (i == 150) do_reset(3);
        end

        // After a mid-run reset the kernel is back to identity
        do_reset(2);
        drive_const(24'hA5C33C, 1'b1, 8);
        check("post_rst_identity", 32'(dout), 32'hA5C33C);
        for (int i = 0; i < 40; i++)
            drive(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
                  {2'($urandom), 1'($urandom_range(0, 3) != 0)}, 1'b0, 5'd0, 8'd0);

        // Drain the outstanding expected outputs
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
